// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: the 13-bit decoder control word,
// ALU operation encodings and forwarding-select codes.
package mips_pkg;

  // ALU operation encodings produced by the main decoder
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_OR    = 3'b011,
    ALU_AND   = 3'b100,
    ALU_SLT   = 3'b101
  } aluop_e;

  // Decoder word, MSB first: {Bne,ExtOp,RegWrite,RegDst,AluSrc,Branch,
  // MemWrite,MemToReg,Jump,AluOp,DEn}
  typedef struct packed {
    logic       bne;
    logic       extop;
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic [2:0] aluop;
    logic       den;
  } ctl_t;

  // A bubble is the all-zero word: it writes nothing and never branches
  localparam ctl_t CTL_BUBBLE = '0;

  // Operand source selects for the EX-stage ALU inputs
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding unit: chooses the source of each EX-stage ALU operand.
// The MEM-stage result is younger than the WB-stage result, so it wins
// when both target the same register. Register $0 is never forwarded.
module fwd_unit
  import mips_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] RsE,
  input  logic [RA_W-1:0] RtE,
  input  logic [RA_W-1:0] WriteRegM,
  input  logic [RA_W-1:0] WriteRegW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE
);

  // Source select for one operand register number
  function automatic logic [1:0] pick(
    input logic [RA_W-1:0] src,
    input logic [RA_W-1:0] wr_m,
    input logic [RA_W-1:0] wr_w,
    input logic            rw_m,
    input logic            rw_w
  );
    if (rw_m && (wr_m != '0) && (wr_m == src)) return FWD_MEM;
    if (rw_w && (wr_w != '0) && (wr_w == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  // Independent selects for the rs and rt operands
  assign ForwardAE = pick(RsE, WriteRegM, WriteRegW, RegWriteM, RegWriteW);
  assign ForwardBE = pick(RtE, WriteRegM, WriteRegW, RegWriteM, RegWriteW);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: carries the decoder word
// through ID/EX, EX/MEM and MEM/WB, detects load-use and control hazards,
// and drives stall, flush and forwarding selects.
// Optional feature macro: PIPE_PERF_EN adds saturating StallCnt/FlushCnt.
module pipe_ctrl
  import mips_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int AOP_W = 3,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AOP_W+9:0]  CtlD,
  input  logic [RA_W-1:0]   RsD,
  input  logic [RA_W-1:0]   RtD,
  input  logic [RA_W-1:0]   RdD,
  input  logic              UsesRtD,
  input  logic              ZeroE,
  output logic [AOP_W+9:0]  CtlE,
  output logic [RA_W-1:0]   WriteRegE,
  output logic [RA_W-1:0]   WriteRegM,
  output logic [RA_W-1:0]   WriteRegW,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              MemWriteM,
  output logic              MemToRegM,
  output logic              MemToRegW,
  output logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
`endif
);

  ctl_t            ctl_d;
  ctl_t            ctl_e;
  logic [RA_W-1:0] rs_e;
  logic [RA_W-1:0] rt_e;
  logic [RA_W-1:0] rd_e;
  logic            LoadUse;
  logic            FlushE;

  assign ctl_d = ctl_t'(CtlD);
  assign CtlE  = ctl_e;

  // EX-stage decode of the registered word
  assign WriteRegE = ctl_e.regdst ? rd_e : rt_e;
  assign PCSrcE    = ctl_e.branch & (ZeroE ^ ctl_e.bne);

  // Hazard detection: a load in EX feeding the instruction in ID
  assign LoadUse = ctl_e.regwrite & ctl_e.memtoreg & (WriteRegE != '0) &
                   ((WriteRegE == RsD) | (UsesRtD & (WriteRegE == RtD)));

  // A taken branch squashes the stalled instruction instead of holding it
  assign StallD = LoadUse & ~PCSrcE;
  assign StallF = StallD;
  assign FlushE = LoadUse | PCSrcE;

  // A jump held by a stall flushes IF/ID only once it leaves ID; the
  // reset term keeps every output low while reset is held
  assign FlushD = ~reset & (PCSrcE | (ctl_d.jump & ~StallD));

  // ID/EX register: loads a bubble on a load-use stall or a taken branch.
  // An X word is passed through unchanged rather than sanitised.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_e <= CTL_BUBBLE;
      rs_e  <= '0;
      rt_e  <= '0;
      rd_e  <= '0;
    end else if (FlushE) begin
      ctl_e <= CTL_BUBBLE;
      rs_e  <= '0;
      rt_e  <= '0;
      rd_e  <= '0;
    end else begin
      ctl_e <= ctl_d;
      rs_e  <= RsD;
      rt_e  <= RtD;
      rd_e  <= RdD;
    end
  end

  // EX/MEM and MEM/WB registers advance every cycle; reset drops in-flight writes
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemToRegM <= 1'b0;
      WriteRegM <= '0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      WriteRegW <= '0;
    end else begin
      RegWriteM <= ctl_e.regwrite;
      MemWriteM <= ctl_e.memwrite;
      MemToRegM <= ctl_e.memtoreg;
      WriteRegM <= WriteRegE;
      RegWriteW <= RegWriteM;
      MemToRegW <= MemToRegM;
      WriteRegW <= WriteRegM;
    end
  end

  // Operand forwarding selects for the EX-stage instruction
  fwd_unit #(
    .RA_W (RA_W)
  ) u_fwd (
    .RsE       (rs_e),
    .RtE       (rt_e),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

`ifdef PIPE_PERF_EN
  // Saturating counters of stalled cycles and EX-flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushE && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: reset, forwarding, $0,
// load-use, branch/jump flushes, combined hazards, mid-stream reset and
// X pass-through.
module tb_pipe_ctrl;

  // Hand-built decoder words {Bne,ExtOp,RegWrite,RegDst,AluSrc,Branch,MemWrite,MemToReg,Jump,AluOp,DEn}
  localparam logic [12:0] NOP   = 13'b0_0_0_0_0_0_0_0_0_000_0;
  localparam logic [12:0] ADDI  = 13'b0_1_1_0_1_0_0_0_0_000_0;
  localparam logic [12:0] LW    = 13'b0_1_1_0_1_0_0_1_0_000_0;
  localparam logic [12:0] RTYPE = 13'b0_0_1_1_0_0_0_0_0_010_0;
  localparam logic [12:0] BEQ   = 13'b0_0_0_0_0_1_0_0_0_001_0;
  localparam logic [12:0] BNE   = 13'b1_0_0_0_0_1_0_0_0_001_0;
  localparam logic [12:0] JMP   = 13'b0_0_0_0_0_0_0_0_1_000_0;
  // Illegal word: load that also branches, used to force LoadUse and PCSrcE together
  localparam logic [12:0] LWBR  = 13'b0_1_1_0_1_1_0_1_0_000_0;

  logic        clk;
  logic        reset;
  logic [12:0] CtlD;
  logic [4:0]  RsD, RtD, RdD;
  logic        UsesRtD;
  logic        ZeroE;
  logic [12:0] CtlE;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteM, RegWriteW, MemWriteM, MemToRegM, MemToRegW;
  logic        PCSrcE, StallF, StallD, FlushD;
  logic [1:0]  ForwardAE, ForwardBE;
`ifdef PIPE_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [12:0] xword;

  pipe_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .CtlD      (CtlD),
    .RsD       (RsD),
    .RtD       (RtD),
    .RdD       (RdD),
    .UsesRtD   (UsesRtD),
    .ZeroE     (ZeroE),
    .CtlE      (CtlE),
    .WriteRegE (WriteRegE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemWriteM (MemWriteM),
    .MemToRegM (MemToRegM),
    .MemToRegW (MemToRegW),
    .PCSrcE    (PCSrcE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
`ifdef PIPE_PERF_EN
    ,
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [12:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic ur);
    CtlD    = c;
    RsD     = rs;
    RtD     = rt;
    RdD     = rd;
    UsesRtD = ur;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for 3 cycles
    reset = 1'b1;
    ZeroE = 1'b0;
    drive(NOP, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_ctle", CtlE, 0);
    check("rst_wre", WriteRegE, 0);
    check("rst_wrm", WriteRegM, 0);
    check("rst_wrw", WriteRegW, 0);
    check("rst_rwm", RegWriteM, 0);
    check("rst_rww", RegWriteW, 0);
    check("rst_mwm", MemWriteM, 0);
    check("rst_m2rm", MemToRegM, 0);
    check("rst_m2rw", MemToRegW, 0);
    check("rst_pcsrc", PCSrcE, 0);
    check("rst_stallf", StallF, 0);
    check("rst_stalld", StallD, 0);
    check("rst_flushd", FlushD, 0);
    check("rst_fa", ForwardAE, 0);
    check("rst_fb", ForwardBE, 0);

    // addi $1,$0,5 reaches EX one cycle after release
    reset = 1'b0;
    drive(ADDI, 0, 1, 0, 0);
    tick();
    check("addi_ctle", CtlE, ADDI);
    check("addi_wre", WriteRegE, 1);

    // add $3,$1,$2 consumes addi result from MEM
    drive(RTYPE, 1, 2, 3, 1);
    tick();
    check("add_fa_mem", ForwardAE, 2'b10);
    check("add_fb_rf", ForwardBE, 2'b00);
    check("add_rwm", RegWriteM, 1);
    check("add_wrm", WriteRegM, 1);

    // sub $4,$3,$3 immediately after add
    drive(RTYPE, 3, 3, 4, 1);
    tick();
    check("sub_fa_mem", ForwardAE, 2'b10);
    check("sub_fb_mem", ForwardBE, 2'b10);
    check("sub_wrw", WriteRegW, 1);
    check("sub_rww", RegWriteW, 1);

    // or $6,$3,$4: $3 two back (WB), $4 one back (MEM)
    drive(RTYPE, 3, 4, 6, 1);
    tick();
    check("or_fa_wb", ForwardAE, 2'b01);
    check("or_fb_mem", ForwardBE, 2'b10);

    // Two writes of $7 back to back: MEM copy wins over WB copy
    drive(ADDI, 0, 7, 0, 0);
    tick();
    drive(ADDI, 0, 7, 0, 0);
    tick();
    drive(RTYPE, 7, 6, 8, 1);
    tick();
    check("prio_fa_mem", ForwardAE, 2'b10);
    check("prio_fb_rf", ForwardBE, 2'b00);

    // addi $0,$0,5 then add $5,$0,$0: no forwarding, no stall
    drive(ADDI, 0, 0, 0, 0);
    tick();
    drive(RTYPE, 0, 0, 5, 1);
    #1;
    check("r0_nostall", StallD, 0);
    tick();
    check("r0_fa", ForwardAE, 2'b00);
    check("r0_fb", ForwardBE, 2'b00);

    // lw $0 followed by a reader of $0: no load-use stall
    drive(LW, 29, 0, 0, 0);
    tick();
    drive(RTYPE, 0, 0, 9, 1);
    #1;
    check("r0_load_stalld", StallD, 0);
    check("r0_load_stallf", StallF, 0);
    tick();

    // lw $8 then add $9,$8,$8: one stall, a bubble, then WB forwarding
    drive(LW, 29, 8, 0, 0);
    tick();
    drive(RTYPE, 8, 8, 9, 1);
    #1;
    check("lu_stallf", StallF, 1);
    check("lu_stalld", StallD, 1);
    check("lu_flushd", FlushD, 0);
    tick();
    check("lu_bubble_ctle", CtlE, 0);
    check("lu_bubble_wre", WriteRegE, 0);
    check("lu_release", StallD, 0);
    check("lu_m2rm", MemToRegM, 1);
    check("lu_wrm", WriteRegM, 8);
    tick();
    check("lu_fa_wb", ForwardAE, 2'b01);
    check("lu_fb_wb", ForwardBE, 2'b01);
    check("lu_m2rw", MemToRegW, 1);

    // Taken beq: PCSrcE and FlushD, wrong-path instruction becomes a bubble
    drive(BEQ, 1, 2, 0, 1);
    tick();
    ZeroE = 1'b1;
    drive(ADDI, 0, 10, 0, 0);
    #1;
    check("beq_pcsrc", PCSrcE, 1);
    check("beq_flushd", FlushD, 1);
    check("beq_nostall", StallD, 0);
    tick();
    check("beq_bubble", CtlE, 0);
    check("beq_bubble_pcsrc", PCSrcE, 0);
    ZeroE = 1'b0;

    // bne: not taken with ZeroE=1, taken with ZeroE=0
    drive(BNE, 1, 2, 0, 1);
    tick();
    ZeroE = 1'b1;
    drive(ADDI, 0, 10, 0, 0);
    #1;
    check("bne_z1_pcsrc", PCSrcE, 0);
    check("bne_z1_flushd", FlushD, 0);
    ZeroE = 1'b0;
    #1;
    check("bne_z0_pcsrc", PCSrcE, 1);
    check("bne_z0_flushd", FlushD, 1);
    tick();
    check("bne_bubble", CtlE, 0);

    // Load-use and taken branch together: flush wins, no stall
    drive(LWBR, 29, 8, 0, 0);
    tick();
    drive(RTYPE, 8, 0, 9, 1);
    #1;
    check("comb_lu_only_stall", StallD, 1);
    ZeroE = 1'b1;
    #1;
    check("comb_pcsrc", PCSrcE, 1);
    check("comb_stallf", StallF, 0);
    check("comb_stalld", StallD, 0);
    check("comb_flushd", FlushD, 1);
    tick();
    check("comb_bubble_ctle", CtlE, 0);
    check("comb_bubble_wre", WriteRegE, 0);
    ZeroE = 1'b0;

    // Jump held by a load-use stall flushes IF/ID only on release
    drive(LW, 29, 8, 0, 0);
    tick();
    drive(JMP, 8, 0, 0, 0);
    #1;
    check("jheld_stalld", StallD, 1);
    check("jheld_flushd", FlushD, 0);
    tick();
    check("jrel_stalld", StallD, 0);
    check("jrel_flushd", FlushD, 1);
    tick();
    check("j_in_ex", CtlE, JMP);

    // Reset mid-stream drops in-flight writes
    drive(ADDI, 0, 11, 0, 0);
    tick();
    drive(ADDI, 0, 12, 0, 0);
    tick();
    check("pre_rst_rwm", RegWriteM, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_rwm", RegWriteM, 0);
    check("mid_rst_rww", RegWriteW, 0);
    check("mid_rst_ctle", CtlE, 0);
    reset = 1'b0;

    // X control word passes through unchanged
    xword = 'x;
    drive(xword, 0, 0, 0, 0);
    tick();
    check("x_pass", CtlE, {19'b0, xword});

    // Final clean-up reset
    drive(NOP, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    check("final_rst_ctle", CtlE, 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
